// File: rtl/error_writer.sv
// error_writer: result-side sink of the regression datapath.
// Captures each error word strobed by the error checker into an internal
// result memory at consecutive addresses, raises done once DEPTH words have
// been stored, and offers a registered read port with read-before-write
// behaviour.
// Optional feature macro: ERROR_WRITER_MAXABS_EN builds a running |e_in|
// maximum tracker on the max_abs port; without it max_abs is tied to zero.
module error_writer #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 150,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  e_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [WIDTH-1:0]  max_abs
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A_C = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A_C = {ADDR_W{1'b0}};
    localparam logic [WIDTH-1:0]  ZERO_W_C = {WIDTH{1'b0}};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] count_next_s;
    logic              overflow_r;
    logic              overflow_next_s;
    logic              mem_we_s;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  rd_data_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];

    // Next-state, counter and overflow decode; start always wins over wr_en.
    always_comb begin
        state_next_s    = state_r;
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        mem_we_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s    = S_COLLECT;
                    count_next_s    = ZERO_A_C;
                    overflow_next_s = 1'b0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (start) begin
                    state_next_s    = S_COLLECT;
                    count_next_s    = ZERO_A_C;
                    overflow_next_s = 1'b0;
                end else if (wr_en) begin
                    mem_we_s     = 1'b1;
                    count_next_s = count_r + ONE_A_C;
                    if (count_r == LAST_C) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_COLLECT;
                    end
                end else begin
                    state_next_s = S_COLLECT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next_s    = S_COLLECT;
                    count_next_s    = ZERO_A_C;
                    overflow_next_s = 1'b0;
                end else if (wr_en) begin
                    overflow_next_s = 1'b1;
                end else begin
                    overflow_next_s = overflow_r;
                end
            end
            default: begin
                state_next_s    = S_IDLE;
                count_next_s    = ZERO_A_C;
                overflow_next_s = 1'b0;
            end
        endcase
    end

    // Control state registers; busy/done registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            count_r    <= ZERO_A_C;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
            busy_r     <= (state_next_s == S_COLLECT);
            done_r     <= (state_next_s == S_DONE);
        end
    end

    // Result memory write port; contents deliberately survive reset and start.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[count_r] <= e_in;
        end
    end

    // Registered read port; out-of-range addresses read as zero, same-edge writes return the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= ZERO_W_C;
        end else if (rd_addr < DEPTH_C) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= ZERO_W_C;
        end
    end

`ifdef ERROR_WRITER_MAXABS_EN
    localparam logic [WIDTH-1:0] MIN_NEG_C = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS_C = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONE_W_C   = {{(WIDTH-1){1'b0}}, 1'b1};

    // Magnitude of a two's-complement word; the most negative value saturates.
    function automatic logic [WIDTH-1:0] abs_sat(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (!v[WIDTH-1]) begin
            r = v;
        end else if (v == MIN_NEG_C) begin
            r = MAX_POS_C;
        end else begin
            r = ~v + ONE_W_C;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] mag_s;
    logic [WIDTH-1:0] max_abs_r;

    // Magnitude of the incoming word.
    always_comb begin
        mag_s = abs_sat(e_in);
    end

    // Running maximum of accepted-write magnitudes; start opens a fresh pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_abs_r <= ZERO_W_C;
        end else if (start) begin
            max_abs_r <= ZERO_W_C;
        end else if (mem_we_s && (mag_s > max_abs_r)) begin
            max_abs_r <= mag_s;
        end else begin
            max_abs_r <= max_abs_r;
        end
    end

    assign max_abs = max_abs_r;
`else
    assign max_abs = ZERO_W_C;
`endif

    assign rd_data  = rd_data_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_error_writer.sv
// Self-checking bench for error_writer: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all compared against a
// pass-level behavioural model kept in this file.
module tb_error_writer;

    localparam int WIDTH  = 20;
    localparam int DEPTH  = 150;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              wr_en;
    logic [WIDTH-1:0]  e_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic [ADDR_W-1:0] count;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [WIDTH-1:0]  max_abs;

    error_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .e_in(e_in),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .busy(busy),
        .done(done), .overflow(overflow), .max_abs(max_abs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a pass is "armed" after start; it is full at DEPTH words.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_written [DEPTH];
    bit               m_armed;
    int               m_count;
    bit               m_ovf;
    int               m_max;
    logic [WIDTH-1:0] m_rd;
    bit               m_rd_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int magnitude(input logic [WIDTH-1:0] v);
        int sv;
        sv = int'($signed(v));
        if (sv < 0) sv = -sv;
        if (sv > (2**(WIDTH-1)) - 1) sv = (2**(WIDTH-1)) - 1;
        return sv;
    endfunction

    task automatic model_reset();
        m_armed    = 1'b0;
        m_count    = 0;
        m_ovf      = 1'b0;
        m_max      = 0;
        m_rd       = '0;
        m_rd_known = 1'b1;
    endtask

    task automatic model_edge(input bit s, input bit w, input logic [WIDTH-1:0] e, input int a);
        if (a < DEPTH) begin
            m_rd_known = m_written[a];
            m_rd       = m_mem[a];
        end else begin
            m_rd_known = 1'b1;
            m_rd       = '0;
        end
        if (s) begin
            m_armed = 1'b1;
            m_count = 0;
            m_ovf   = 1'b0;
            m_max   = 0;
        end else if (w && m_armed) begin
            if (m_count < DEPTH) begin
                m_mem[m_count]     = e;
                m_written[m_count] = 1'b1;
                m_count++;
`ifdef ERROR_WRITER_MAXABS_EN
                if (magnitude(e) > m_max) m_max = magnitude(e);
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".busy"}, 32'(busy), 32'(m_armed && (m_count < DEPTH)));
        check({tag, ".done"}, 32'(done), 32'(m_armed && (m_count == DEPTH)));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".max_abs"}, 32'(max_abs), 32'(m_max));
        if (m_rd_known) check({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge.
    task automatic tick(input string tag, input bit s, input bit w, input logic [WIDTH-1:0] e, input int a);
        start   = s;
        wr_en   = w;
        e_in    = e;
        rd_addr = ADDR_W'(a);
        @(posedge clk);
        model_edge(s, w, e, a);
        @(negedge clk);
        compare_all(tag);
    endtask

    typedef struct {
        bit               s;
        bit               w;
        logic [WIDTH-1:0] e;
        int               exp_count;
        bit               exp_busy;
        bit               exp_done;
    } vec_t;

    vec_t vt [7];
    int   exp_max [4];
    logic [WIDTH-1:0] max_seq [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_written[i] = 1'b0;
            m_mem[i]     = '0;
        end
        model_reset();
        rst = 1'b0; start = 1'b0; wr_en = 1'b0; e_in = '0; rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        rst = 1'b1;

        // Directed table: IDLE ignores writes, start+wr drops the word, restart clears count.
        vt[0] = '{s: 1'b0, w: 1'b1, e: 20'h00007, exp_count: 0, exp_busy: 1'b0, exp_done: 1'b0};
        vt[1] = '{s: 1'b1, w: 1'b1, e: 20'h00009, exp_count: 0, exp_busy: 1'b1, exp_done: 1'b0};
        vt[2] = '{s: 1'b0, w: 1'b1, e: 20'h00011, exp_count: 1, exp_busy: 1'b1, exp_done: 1'b0};
        vt[3] = '{s: 1'b0, w: 1'b1, e: 20'h00022, exp_count: 2, exp_busy: 1'b1, exp_done: 1'b0};
        vt[4] = '{s: 1'b1, w: 1'b1, e: 20'h00033, exp_count: 0, exp_busy: 1'b1, exp_done: 1'b0};
        vt[5] = '{s: 1'b0, w: 1'b1, e: 20'h00044, exp_count: 1, exp_busy: 1'b1, exp_done: 1'b0};
        vt[6] = '{s: 1'b0, w: 1'b0, e: 20'h00055, exp_count: 1, exp_busy: 1'b1, exp_done: 1'b0};
        for (int i = 0; i < 7; i++) begin
            tick($sformatf("vec%0d", i), vt[i].s, vt[i].w, vt[i].e, 0);
            check($sformatf("vec%0d.tcount", i), 32'(count), 32'(vt[i].exp_count));
            check($sformatf("vec%0d.tbusy", i), 32'(busy), 32'(vt[i].exp_busy));
            check($sformatf("vec%0d.tdone", i), 32'(done), 32'(vt[i].exp_done));
        end

        // Full pass of DEPTH consecutive writes, then read everything back.
        tick("full.start", 1'b1, 1'b0, '0, 0);
        for (int i = 0; i < DEPTH; i++) tick("full.wr", 1'b0, 1'b1, WIDTH'(i), 0);
        check("full.count150", 32'(count), 32'd150);
        check("full.done", 32'(done), 32'd1);
        check("full.busy", 32'(busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            tick("full.rd", 1'b0, 1'b0, '0, i);
            check($sformatf("full.rd%0d", i), 32'(rd_data), 32'(i));
        end
        tick("full.rd_oob", 1'b0, 1'b0, '0, 200);
        check("full.rd_oob0", 32'(rd_data), 32'd0);

        // Write attempt in DONE: sticky overflow, no memory change.
        tick("ovf.wr", 1'b0, 1'b1, 20'hABCDE, 149);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.count", 32'(count), 32'd150);
        tick("ovf.rd", 1'b0, 1'b0, '0, 149);
        check("ovf.mem149", 32'(rd_data), 32'd149);
        tick("ovf.sticky", 1'b0, 1'b0, '0, 149);
        check("ovf.sticky1", 32'(overflow), 32'd1);

        // Restart at count 10 with a concurrent write.
        tick("rs.start", 1'b1, 1'b0, '0, 0);
        check("rs.ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) tick("rs.wr", 1'b0, 1'b1, WIDTH'(32'h100 + i), 0);
        tick("rs.restart", 1'b1, 1'b1, 20'h12345, 0);
        check("rs.count0", 32'(count), 32'd0);
        tick("rs.wr0", 1'b0, 1'b1, 20'h55555, 0);
        check("rs.rbw_old", 32'(rd_data), 32'h100);
        tick("rs.rd0", 1'b0, 1'b0, '0, 10);
        check("rs.rd10_old", 32'(rd_data), 32'd10);
        tick("rs.rd0b", 1'b0, 1'b0, '0, 0);
        check("rs.addr0", 32'(rd_data), 32'h55555);

        // Asynchronous reset mid-pass at count 40.
        tick("ar.start", 1'b1, 1'b0, '0, 5);
        for (int i = 0; i < 40; i++) tick("ar.wr", 1'b0, 1'b1, WIDTH'(32'h200 + i), 5);
        tick("ar.rd", 1'b0, 1'b0, '0, 5);
        check("ar.pre_rd", 32'(rd_data), 32'h205);
        #2 rst = 1'b0;
        #1;
        check("ar.busy", 32'(busy), 32'd0);
        check("ar.count", 32'(count), 32'd0);
        check("ar.rd_data", 32'(rd_data), 32'd0);
        check("ar.overflow", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick("ar.ignored", 1'b0, 1'b1, 20'h00777, 5);
        check("ar.idle_count", 32'(count), 32'd0);
        check("ar.mem_kept", 32'(rd_data), 32'h205);

        // max_abs sequence.
        max_seq[0] = 20'h00005; max_seq[1] = 20'hFFED4; max_seq[2] = 20'h00078; max_seq[3] = 20'h80000;
`ifdef ERROR_WRITER_MAXABS_EN
        exp_max[0] = 5; exp_max[1] = 300; exp_max[2] = 300; exp_max[3] = 32'h7FFFF;
`else
        exp_max[0] = 0; exp_max[1] = 0; exp_max[2] = 0; exp_max[3] = 0;
`endif
        tick("mx.start", 1'b1, 1'b0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            tick("mx.wr", 1'b0, 1'b1, max_seq[i], 0);
            check($sformatf("mx.step%0d", i), 32'(max_abs), 32'(exp_max[i]));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit               rs;
            bit               rw;
            logic [WIDTH-1:0] re;
            rs = ($urandom_range(0, 249) == 0);
            rw = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 15) == 0) ? 20'h80000 : WIDTH'($urandom);
            tick("rnd", rs, rw, re, int'($urandom_range(0, 159)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
